cnt_slice_reg: RTL and testbench
================================

Name: cnt_slice_reg

Overview:
- Registered, cascadable synchronous counter built from NSLICE 4-bit slices.
- Holds the counter state and applies one of four per-cycle operations: hold, count, parallel load or clear.
- Each slice's next state is computed combinationally. All state updates on the rising clock edge.
- The terminal-count output has the same form as the 163-style carry-out (enable AND terminal pattern), so stages can be chained.

Parameters:
- NSLICE, 2, number of 4-bit slices; total counter width W = 4*NSLICE.
- RST_VAL, 0, value loaded into q on reset (W bits, truncated).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- op  input  2  operation select: 00 hold, 01 count, 10 load, 11 clear.
- dir  input  1  count direction: 1 = down (borrow chain), 0 = up (carry chain).
- enp  input  1  count enable, parallel; gates counting only.
- ent  input  1  count enable, trickle; gates counting and tc.
- d  input  W  parallel load value.
- q  output  W  registered counter value.
- tc  output  1  terminal count, combinational: ent & (q == terminal pattern for current dir).
- wrap  output  1  registered one-cycle pulse, asserted the cycle after a count wraps.
- busy_cnt  output  1  registered; high while the last accepted op was an effective count.

Behaviour:
- Reset (asynchronous, rst=1): q = RST_VAL, wrap = 0, busy_cnt = 0, regardless of clk. tc then follows from q and ent.
- Terminal pattern: all zeros when dir = 1; all ones when dir = 0.
- Per rising edge with rst = 0, op is decoded with a fixed encoding and therefore needs no priority:
  - 11 clear: q <= 0. Ignores enp, ent and dir. wrap <= 0.
  - 10 load: q <= d. Ignores enables. wrap <= 0.
  - 01 count, with enp & ent = 1: q <= q-1 (dir=1) or q+1 (dir=0), modulo 2^W.
    - wrap <= 1 iff q was at the terminal pattern before the edge.
    - Example: 0 -> all ones when counting down.
  - 01 count, with enp & ent = 0: q holds, wrap <= 0.
  - 00 hold: q holds, wrap <= 0.
- busy_cnt <= (op == 01) & enp & ent. Cleared by every other op.
- Latency: q reflects an op one cycle after it is presented. wrap is aligned with the q value that follows the wrap. tc has zero-cycle latency from q, ent and dir.
- Slice chaining: slice k toggles/steps only when slice-enable(k) = 1.
  - slice-enable(0) = enp & ent.
  - slice-enable(k+1) = slice-enable(k) & (slice k at its 4-bit terminal pattern).
  - Result: full-width arithmetic identical to a single W-bit add/subtract.
- Changing dir while counting takes effect on the next edge. tc may glitch combinationally in the same cycle; consumers sample it on the clock.
- Reset asserted mid-count overrides any op immediately. Release is synchronous to the first edge with rst = 0, which then executes op normally.
- Load of the terminal pattern does not set wrap. A subsequent count from it does.
- Undriven (X) op in simulation: assertion error; RTL behaviour is unspecified.

Decomposition:
- Package cnt_pkg:
  - op encodings OP_HOLD=2'b00, OP_CNT=2'b01, OP_LOAD=2'b10, OP_CLR=2'b11.
  - DIR_UP=1'b0, DIR_DOWN=1'b1.
  - Function term_pat(dir, width).
- Sub-module cnt4_next:
  - Purely combinational per-slice next-state.
  - Inputs: 4-bit current, 4-bit load, op, dir, slice enable in.
  - Outputs: 4-bit next value, slice enable out (cascade).
  - The top generates NSLICE instances and owns all registers.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with q=8'h5A (NSLICE=2) -> q=8'h00, wrap=0, busy_cnt=0 immediately, with no clock edge.
- Load/count down: load d=8'h02, then op=01, enp=ent=1, dir=1 for 3 edges -> q: 02,01,00,FF. tc=1 while q=00. wrap=1 only in the cycle q=FF.
- Count up across a slice boundary: load 8'h0F, count with dir=0 -> q=8'h10. Next edges 11,12. Check slice 1 steps exactly once.
- Enable gating: q=8'h00, dir=1, ent=0, enp=1, op=01 -> q holds 00, tc=0, busy_cnt=0. Then ent=1, enp=0 -> q holds, tc=1.
- Op decoding: op=11 with enp=ent=1 and q=8'h33 -> q=00, wrap=0. Then op=10 with d=8'hFF, dir=0 -> q=FF, wrap=0, tc=1. Next count -> q=00, wrap=1.
- Reset during count: counting up from 8'hFE, assert rst as the counter reaches FF -> q=00, wrap=0. Release rst with op=01 -> first post-release edge gives q=01.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared encodings and helpers for the cascadable slice counter.
package cnt_pkg;

   // Operation select encoding (fixed one-hot-free decode, no priority needed)
   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_CNT  = 2'b01;
   localparam logic [1:0] OP_LOAD = 2'b10;
   localparam logic [1:0] OP_CLR  = 2'b11;

   // Count direction
   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // Widest counter the terminal-pattern helper can describe
   localparam int TERM_MAX_W = 64;

   // Terminal pattern for a counter of the given width: all ones when
   // counting up, all zeros when counting down. Bits above width are zero.
   function automatic logic [TERM_MAX_W-1:0] term_pat(input logic dir, input int width);
      logic [TERM_MAX_W-1:0] pat;
      pat = '0;
      for (int i = 0; i < TERM_MAX_W; i++) begin
         if (i < width) begin
            pat[i] = (dir == DIR_UP);
         end
      end
      return pat;
   endfunction

endpackage

// File: rtl/cnt4_next.sv
// Combinational next-state for one 4-bit counter slice, with the
// carry/borrow enable passed on to the next slice up.
module cnt4_next
   import cnt_pkg::*;
(
   input  logic [3:0] cur,
   input  logic [3:0] ld,
   input  logic [1:0] op,
   input  logic       dir,
   input  logic       en_in,
   output logic [3:0] nxt,
   output logic       en_out
);

   logic slice_term;

   // Slice sits at its own terminal pattern; the next slice steps only then
   always_comb begin
      slice_term = (dir == DIR_DOWN) ? (cur == 4'h0) : (cur == 4'hF);
      en_out     = en_in & slice_term;
   end

   // Next slice value for the decoded operation
   always_comb begin
      nxt = cur;
      case (op)
         OP_HOLD: nxt = cur;
         OP_CNT: begin
            if (en_in) begin
               nxt = (dir == DIR_DOWN) ? cur - 4'd1 : cur + 4'd1;
            end
         end
         OP_LOAD: nxt = ld;
         OP_CLR:  nxt = 4'h0;
         default: nxt = cur;
      endcase
   end

endmodule

// File: rtl/cnt_slice_reg.sv
// Registered counter assembled from NSLICE 4-bit slices. The slices only
// compute next state; every register lives here. Width is limited to
// TERM_MAX_W bits by the terminal-pattern helper.
module cnt_slice_reg
   import cnt_pkg::*;
#(
   parameter int                  NSLICE  = 2,
   parameter logic [4*NSLICE-1:0] RST_VAL = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            op,
   input  logic                  dir,
   input  logic                  enp,
   input  logic                  ent,
   input  logic [4*NSLICE-1:0]   d,
   output logic [4*NSLICE-1:0]   q,
   output logic                  tc,
   output logic                  wrap,
   output logic                  busy_cnt
);

   localparam int W = 4 * NSLICE;

   logic [W-1:0]            q_q;
   logic [W-1:0]            q_d;
   logic                    wrap_q;
   logic                    wrap_d;
   logic                    busy_q;
   logic                    busy_d;
   logic [NSLICE:0]         slice_en;
   logic [TERM_MAX_W-1:0]   q_ext;
   logic [TERM_MAX_W-1:0]   term_full;

   // Lowest slice steps whenever both count enables are high
   assign slice_en[0] = enp & ent;

   genvar gi;
   generate
      for (gi = 0; gi < NSLICE; gi++) begin : g_slice
         cnt4_next u_slice (
            .cur    (q_q[4*gi +: 4]),
            .ld     (d[4*gi +: 4]),
            .op     (op),
            .dir    (dir),
            .en_in  (slice_en[gi]),
            .nxt    (q_d[4*gi +: 4]),
            .en_out (slice_en[gi+1])
         );
      end
   endgenerate

   // Full-width enable out of the top slice means every slice was terminal,
   // i.e. this count edge wraps the whole counter
   always_comb begin
      wrap_d = (op == OP_CNT) & slice_en[NSLICE];
      busy_d = (op == OP_CNT) & enp & ent;
   end

   // Terminal count is combinational from q, ent and dir for cascading
   always_comb begin
      q_ext          = '0;
      q_ext[W-1:0]   = q_q;
      term_full      = term_pat(dir, W);
      tc             = ent & (q_ext == term_full);
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q    <= RST_VAL;
         wrap_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
         busy_q <= busy_d;
      end
   end

   // Flag an undriven operation select while out of reset
   always @(posedge clk) begin
      if (!rst) begin
         assert (!$isunknown(op)) else $error("cnt_slice_reg: op is X/Z");
      end
   end

   assign q        = q_q;
   assign wrap     = wrap_q;
   assign busy_cnt = busy_q;

endmodule

// File: tb/tb_cnt_slice_reg.sv
// Self-checking bench for cnt_slice_reg: directed scenarios followed by a
// random operation stream, all checked against an arithmetic model.
module tb_cnt_slice_reg;

   localparam int NSLICE = 2;
   localparam int W      = 4 * NSLICE;
   localparam int unsigned MOD = 1 << W;

   logic          clk;
   logic          rst;
   logic [1:0]    op;
   logic          dir;
   logic          enp;
   logic          ent;
   logic [W-1:0]  d;
   logic [W-1:0]  q;
   logic          tc;
   logic          wrap;
   logic          busy_cnt;

   int n_cmp;
   int n_err;

   // Reference model state
   int unsigned m_q;
   logic        m_wrap;
   logic        m_busy;

   cnt_slice_reg #(
      .NSLICE  (NSLICE),
      .RST_VAL ('0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .op       (op),
      .dir      (dir),
      .enp      (enp),
      .ent      (ent),
      .d        (d),
      .q        (q),
      .tc       (tc),
      .wrap     (wrap),
      .busy_cnt (busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_tc(input int unsigned val, input logic dr, input logic et);
      return et && (val == (dr ? 0 : MOD - 1));
   endfunction

   // Present one operation, let one edge pass, then check all outputs
   task automatic apply(input logic [1:0] o, input logic dr, input logic ep,
                        input logic et, input logic [W-1:0] dv);
      op  = o;
      dir = dr;
      enp = ep;
      ent = et;
      d   = dv;
      m_busy = (o == 2'b01) && ep && et;
      m_wrap = 1'b0;
      case (o)
         2'b01: begin
            if (ep && et) begin
               if (dr) begin
                  m_wrap = (m_q == 0);
                  m_q    = (m_q + MOD - 1) % MOD;
               end else begin
                  m_wrap = (m_q == MOD - 1);
                  m_q    = (m_q + 1) % MOD;
               end
            end
         end
         2'b10:   m_q = dv;
         2'b11:   m_q = 0;
         default: ;
      endcase
      @(posedge clk);
      #1;
      $display("op=%b dir=%b enp=%b ent=%b d=%h -> q=%h tc=%b wrap=%b busy=%b",
               o, dr, ep, et, dv, q, tc, wrap, busy_cnt);
      chk("q", 32'(q), 32'(m_q));
      chk("wrap", 32'(wrap), 32'(m_wrap));
      chk("busy_cnt", 32'(busy_cnt), 32'(m_busy));
      chk("tc", 32'(tc), 32'(exp_tc(m_q, dr, et)));
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      op  = 2'b00;
      dir = 1'b0;
      enp = 1'b0;
      ent = 1'b0;
      d   = '0;
      m_q = 0;
      m_wrap = 1'b0;
      m_busy = 1'b0;

      // Power-on reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_wrap", 32'(wrap), 32'h0);
      chk("rst_busy", 32'(busy_cnt), 32'h0);
      chk("rst_tc", 32'(tc), 32'h0);
      rst = 1'b0;

      // Asynchronous reset mid-cycle with q=5A and busy high
      apply(2'b10, 1'b0, 1'b0, 1'b0, 8'h59);
      apply(2'b01, 1'b0, 1'b1, 1'b1, 8'h00);
      #3 rst = 1'b1;
      #1;
      $display("async rst mid-cycle -> q=%h wrap=%b busy=%b", q, wrap, busy_cnt);
      chk("arst_q", 32'(q), 32'h0);
      chk("arst_wrap", 32'(wrap), 32'h0);
      chk("arst_busy", 32'(busy_cnt), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_q = 0;

      // Load and count down through zero
      apply(2'b10, 1'b1, 1'b0, 1'b0, 8'h02);
      apply(2'b01, 1'b1, 1'b1, 1'b1, 8'h00);
      apply(2'b01, 1'b1, 1'b1, 1'b1, 8'h00);
      apply(2'b01, 1'b1, 1'b1, 1'b1, 8'h00);

      // Count up across the slice boundary
      apply(2'b10, 1'b0, 1'b0, 1'b0, 8'h0F);
      for (int i = 0; i < 3; i++) begin
         apply(2'b01, 1'b0, 1'b1, 1'b1, 8'h00);
         chk("slice1", 32'(q[7:4]), 32'h1);
      end

      // Enable gating
      apply(2'b10, 1'b1, 1'b0, 1'b0, 8'h00);
      apply(2'b01, 1'b1, 1'b1, 1'b0, 8'h00);
      apply(2'b01, 1'b1, 1'b0, 1'b1, 8'h00);

      // Op decoding: clear ignores enables, load of terminal does not wrap
      apply(2'b10, 1'b0, 1'b0, 1'b0, 8'h33);
      apply(2'b11, 1'b0, 1'b1, 1'b1, 8'h00);
      apply(2'b10, 1'b0, 1'b1, 1'b1, 8'hFF);
      // tc follows dir with no clock edge
      dir = 1'b1;
      #1;
      $display("dir flip at q=%h -> tc=%b", q, tc);
      chk("tc_dir", 32'(tc), 32'h0);
      dir = 1'b0;
      #1;
      chk("tc_dir_back", 32'(tc), 32'h1);
      apply(2'b01, 1'b0, 1'b1, 1'b1, 8'h00);

      // Reset during count, then release straight into a count
      apply(2'b10, 1'b0, 1'b0, 1'b0, 8'hFE);
      apply(2'b01, 1'b0, 1'b1, 1'b1, 8'h00);
      #3 rst = 1'b1;
      #1;
      $display("async rst at q=FF -> q=%h wrap=%b", q, wrap);
      chk("cnt_rst_q", 32'(q), 32'h0);
      chk("cnt_rst_wrap", 32'(wrap), 32'h0);
      op = 2'b01;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_q = 0;
      apply(2'b01, 1'b0, 1'b1, 1'b1, 8'h00);

      // Random stream biased toward counting so wraps occur
      for (int i = 0; i < 300; i++) begin
         int unsigned r;
         logic [1:0]  o;
         logic [W-1:0] dv;
         r  = $urandom_range(0, 9);
         o  = (r < 6) ? 2'b01 : ((r < 8) ? 2'b10 : ((r < 9) ? 2'b00 : 2'b11));
         dv = W'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            dv = ($urandom_range(0, 1) == 1) ? W'(MOD - 2) : W'(1);
         end
         apply(o, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0),
               ($urandom_range(0, 5) != 0), dv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
